// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data memory access unit.
package mem_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory word-port bundle for mem_access_unit.
interface mem_access_unit_if;

    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] ld_data;
    logic        stall;
    logic        fault;
    logic        fault_sticky;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_b;
    logic [31:0] mem_rd;

    modport slave (
        input  req_read, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output ld_data, stall, fault, fault_sticky, mem_we, mem_a, mem_wd, mem_b
    );

    modport master (
        output req_read, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  ld_data, stall, fault, fault_sticky, mem_we, mem_a, mem_wd, mem_b
    );

endinterface

// File: rtl/load_formatter.sv
// Lane select plus sign/zero extension of a memory word; also exports the
// byte-lane mask so the store merge uses the same decode.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] data,
    output logic [3:0]  lane_mask
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = word >> {addr_lo, 3'b000};
    assign half_shift = word >> {addr_lo[1], 4'b0000};

    always_comb begin
        data      = '0;
        lane_mask = '0;
        case (size)
            SZ_BYTE: begin
                data      = {{24{sext & byte_shift[7]}}, byte_shift[7:0]};
                lane_mask = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                data      = {{16{sext & half_shift[15]}}, half_shift[15:0]};
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                data      = word;
                lane_mask = 4'b1111;
            end
            default: begin
                data      = '0;
                lane_mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data memory: formatted loads, word stores,
// and sub-word stores as a stalled two-cycle read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input logic              clk,
    input logic              reset_n,
    mem_access_unit_if.slave bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) << 2;

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic        fault_sticky_q;

    logic        bad_align;
    logic        out_of_range;
    logic        req_fault;
    logic [31:0] fmt_data;
    logic [3:0]  lane_mask;
    logic [31:0] wdata_rep;
    logic [31:0] merged;

    load_formatter u_fmt (
        .word      (bus.mem_rd),
        .addr_lo   (bus.req_addr[1:0]),
        .size      (bus.req_size),
        .sext      (bus.req_signed),
        .data      (fmt_data),
        .lane_mask (lane_mask)
    );

    always_comb begin
        bad_align = 1'b1;
        case (bus.req_size)
            SZ_BYTE: bad_align = 1'b0;
            SZ_HALF: bad_align = bus.req_addr[0];
            SZ_WORD: bad_align = |bus.req_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    assign out_of_range = bus.req_addr >= ADDR_LIMIT;

    // Requests are only evaluated in IDLE; the RMW_WR cycle ignores them.
    assign req_fault = (state_q == IDLE) && (bus.req_read || bus.req_write) &&
                       ((bus.req_read && bus.req_write) || bad_align || out_of_range);

    assign wdata_rep = (bus.req_size == SZ_BYTE) ? {4{bus.req_wdata[7:0]}}
                                                 : {2{bus.req_wdata[15:0]}};

    always_comb begin
        merged = bus.mem_rd;
        for (int k = 0; k < 4; k++) begin
            if (lane_mask[k]) merged[8*k +: 8] = wdata_rep[8*k +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        bus.stall  = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_wd = bus.req_wdata;
        unique case (state_q)
            IDLE: begin
                if (bus.req_write && !req_fault) begin
                    if (bus.req_size == SZ_WORD) begin
                        bus.mem_we = 1'b1;
                    end else begin
                        bus.stall = 1'b1;
                        merge_d   = merged;
                        state_d   = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                bus.mem_we = 1'b1;
                bus.mem_wd = merge_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            merge_q        <= '0;
            fault_sticky_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            merge_q        <= merge_d;
            fault_sticky_q <= fault_sticky_q | req_fault;
        end
    end

    assign bus.ld_data      = ((state_q == IDLE) && bus.req_read && !req_fault) ? fmt_data : '0;
    assign bus.fault        = req_fault;
    assign bus.fault_sticky = fault_sticky_q;
    assign bus.mem_a        = {bus.req_addr[31:2], 2'b00};
    assign bus.mem_b        = 1'b0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Processor-side initiator for the data memory in the MEM stage of the pipelined MIPS core.
- Takes load/store requests from the EX/MEM pipeline register and drives the data memory's word port (clk, we, a, wd, rd, b).
- Formats load data with byte/halfword selection and sign/zero extension.
- Implements sub-word stores as a two-cycle read-modify-write (RMW) with a pipeline stall. Only whole-word writes (b=0) are issued to memory.
- Flags misaligned and out-of-range accesses.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; byte addresses >= MEM_WORDS*4 are out of range.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_read  in  1  load request this cycle
- req_write  in  1  store request this cycle
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data (right-justified for sub-word)
- ld_data  out  32  formatted load result
- stall  out  1  hold pipeline; request inputs must stay stable while high
- fault  out  1  one-cycle pulse: misaligned/out-of-range/reserved-size request rejected
- fault_sticky  out  1  set by any fault, cleared only by reset
- mem_we  out  1  data memory write enable
- mem_a  out  32  data memory address, always word-aligned (low 2 bits 0)
- mem_wd  out  32  data memory write data
- mem_b  out  1  data memory byte mode; tied to 0 (whole-word writes only)
- mem_rd  in  32  data memory read data (combinational from mem_a)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, stall=0, fault=0, fault_sticky=0, mem_we=0, merge register=0. mem_we and stall derive from state/registers, so both drop immediately on reset assertion.
- Request validity:
  - req_read and req_write both high: treated as a fault, no access.
  - Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; size 11; addr >= MEM_WORDS*4.
  - On a fault: no memory write, ld_data=0, fault pulses high for that cycle, fault_sticky sets on the next edge.
- mem_a = {req_addr[31:2],2'b00} in all states.
- Loads: zero added latency, no stall.
  - Byte lane = addr[1:0]. Byte lane k = mem_rd[8k+7:8k]. Half lane = addr[1] (0 → [15:0], 1 → [31:16]).
  - Extension: sign-extend if req_signed, else zero-extend.
  - ld_data is 0 whenever req_read=0.
- Word store: single cycle. mem_we=1, mem_wd=req_wdata, stall=0.
- Sub-word store FSM (states IDLE, RMW_WR):
  - IDLE, valid byte/half store:
    - stall=1, mem_we=0.
    - merged = mem_rd with the selected lane(s) replaced by req_wdata[7:0] or [15:0].
    - merged is registered; transition to RMW_WR.
  - RMW_WR:
    - mem_we=1, mem_wd=merge register, stall=0; return to IDLE next edge.
    - Request inputs are ignored in this cycle; the pipeline advances at this edge.
  - Back-to-back sub-word stores: each takes exactly 2 cycles (IDLE→RMW_WR→IDLE).
- Reset asserted in RMW_WR: the write is dropped (mem_we falls asynchronously) and memory is unchanged.
- All arithmetic is 32-bit. Lane selection uses addr[1:0] only.

Decomposition:
- Shared package mem_pkg:
  - size enum: SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum: IDLE, RMW_WR
  - MEM_WORDS default constant
- One natural sub-module: load_formatter (combinational lane select + extension). The RMW merge reuses its lane decode.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10 → mem_we for 1 cycle, stall never high; load word @0x10 → ld_data=0xDEADBEEF.
- Signed/unsigned byte loads: mem word 0x80FF7F01 @0x20. lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lb @0x21 → 0x0000007F; lh @0x22 → 0xFFFF80FF.
- Byte store RMW: word @0x30=0x11223344, sb 0xAA @0x31 → stall=1 for 1 cycle, then mem_we with mem_wd=0x1122AA44; reload → 0x1122AA44.
- Half store + back-to-back: sh 0xBEEF @0x32 followed immediately by sb 0x55 @0x30 → word ends as 0xBEEF3355 (from 0x11223344); total 4 cycles, stall high on cycles 1 and 3.
- Faults: lw @0x11, sh @0x13, sw @0x100 (MEM_WORDS=64) → fault pulses each time, no mem_we, fault_sticky=1 until reset_n=0.
- Reset mid-RMW: assert reset_n=0 during RMW_WR → mem_we falls without a clock edge, memory word unchanged, state IDLE, fault_sticky=0.
